// File: rtl/pic_cascade_arbiter_pkg.sv
// rtl/pic_cascade_arbiter_pkg.sv - shared types and helpers for the interrupt cascade arbiter
package pic_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    ACK     = 3'd2,
    FETCH   = 3'd3,
    SERVICE = 3'd4
  } cascade_state_t;

  // Width of a source index; at least one bit so a single source still has a port
  function automatic int src_id_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  // Index the picker reports when no source is requesting
  localparam int PIC_NO_GRANT = 0;

endpackage

// File: rtl/pic_cascade_arbiter_rr_pick.sv
// rtl/pic_cascade_arbiter_rr_pick.sv - combinational round-robin picker starting after ptr_i
module pic_rr_pick
  import pic_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int ID_W   = src_id_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    index_o
);

  // Scan from the farthest candidate back to ptr_i+1 so the nearest requester is written last and wins
  always_comb begin
    logic [ID_W-1:0] cand;
    valid_o = 1'b0;
    index_o = ID_W'(PIC_NO_GRANT);
    cand    = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = ID_W'((int'(ptr_i) + k) % NUM_SRC);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/pic_cascade_arbiter.sv
// rtl/pic_cascade_arbiter.sv - cascades NUM_SRC interrupt controllers onto one CPU line; EOI watchdog under PIC_CASCADE_TIMEOUT_EN
module pic_cascade_arbiter
  import pic_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int VEC_W          = 32,
  parameter int VEC_LAT        = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_req,
  input  logic [NUM_SRC*VEC_W-1:0]    src_vector,
  output logic [NUM_SRC-1:0]          src_ack,
  output logic                        cpu_req,
  input  logic                        cpu_ack,
  input  logic                        cpu_eoi,
  output logic [VEC_W-1:0]            cpu_vector,
  output logic                        cpu_vec_vld,
  output logic [src_id_w(NUM_SRC)-1:0] grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int ID_W  = src_id_w(NUM_SRC);
  localparam int LAT_W = (VEC_LAT > 0) ? $clog2(VEC_LAT + 1) : 1;

  cascade_state_t   state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             vld_q, vld_d;
  logic             pick_vld;
  logic [ID_W-1:0]  pick_idx;
  logic             tmo_hit;
  logic [VEC_W-1:0] src_vec_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_vec
    assign src_vec_arr[i] = src_vector[i*VEC_W +: VEC_W];
  end

  pic_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req_i   (src_req),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_vld),
    .index_o (pick_idx)
  );

`ifdef PIC_CASCADE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;

  // The last SERVICE cycle before expiry; an EOI in that same cycle still wins
  assign tmo_hit   = (state_q == SERVICE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_cnt_d = (state_q == SERVICE) ? tmo_cnt_q + TMO_W'(1) : '0;
  assign tmo_err_d = tmo_hit && !cpu_eoi;

  // Watchdog counter and its one-cycle error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state logic for the grant handshake and vector capture
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    lat_cnt_d = lat_cnt_q;
    vec_d     = vec_q;
    vld_d     = vld_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        // A source that withdraws before the CPU acks is dropped without moving the pointer
        if (cpu_ack) begin
          state_d = ACK;
        end else if (!src_req[grant_q]) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        lat_cnt_d = LAT_W'(VEC_LAT);
        state_d   = FETCH;
      end
      FETCH: begin
        if (lat_cnt_q == '0) begin
          vec_d   = src_vec_arr[grant_q];
          vld_d   = 1'b1;
          state_d = SERVICE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      SERVICE: begin
        if (cpu_eoi || tmo_hit) begin
          rr_ptr_d = grant_q;
          vld_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; the pointer starts at the last source so source 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= ID_W'(NUM_SRC - 1);
      lat_cnt_q <= '0;
      vec_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      lat_cnt_q <= lat_cnt_d;
      vec_q     <= vec_d;
      vld_q     <= vld_d;
    end
  end

  // Acknowledge only the granted controller, only during the ACK cycle
  always_comb begin
    src_ack = '0;
    if (state_q == ACK) begin
      src_ack[grant_q] = 1'b1;
    end
  end

  assign cpu_req     = (state_q == REQ);
  assign busy        = (state_q != IDLE);
  assign cpu_vector  = vec_q;
  assign cpu_vec_vld = vld_q;
  assign grant_id    = grant_q;

endmodule
